// File: rtl/hci_package.sv
// Shared HCI constants and helpers: stall-LFSR width, tap mask, default seed.
package hci_package;

  localparam int unsigned HCI_STALL_LFSR_W = 16;
  // Fibonacci taps 16,14,13,11 -> state bits 15,13,12,10
  localparam logic [HCI_STALL_LFSR_W-1:0] HCI_STALL_LFSR_TAPS = 16'hB400;
  localparam logic [HCI_STALL_LFSR_W-1:0] HCI_STALL_LFSR_SEED = 16'hACE1;

  typedef enum logic {
    HCI_OP_WRITE = 1'b0,
    HCI_OP_READ  = 1'b1
  } hci_op_e;

  function automatic logic [HCI_STALL_LFSR_W-1:0] hci_lfsr_next(
    input logic [HCI_STALL_LFSR_W-1:0] s
  );
    return {s[HCI_STALL_LFSR_W-2:0], ^(s & HCI_STALL_LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/hci_mem_bank_responder_lfsr.sv
// 16-bit Fibonacci stall LFSR with synchronous seed reload.
module hci_mem_bank_responder_lfsr
  import hci_package::*;
#(
  parameter logic [HCI_STALL_LFSR_W-1:0] SEED = HCI_STALL_LFSR_SEED
) (
  input  logic                        i_clk,
  input  logic                        i_rst_n,
  input  logic                        i_en,
  input  logic                        i_clear,
  output logic [HCI_STALL_LFSR_W-1:0] o_state
);

  logic [HCI_STALL_LFSR_W-1:0] r_state;

  // State register: seed on reset/clear, otherwise step when enabled.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= SEED;
    end else if (i_clear) begin
      r_state <= SEED;
    end else if (i_en) begin
      r_state <= hci_lfsr_next(r_state);
    end
  end

  assign o_state = r_state;

endmodule

// File: rtl/hci_mem_bank_responder.sv
// TCDM bank responder: byte-enabled word array, fixed-latency tagged read
// responses, LFSR-driven grant stalling.
// Optional test-and-set reads: define HCI_MEM_BANK_RESPONDER_TS_EN.
module hci_mem_bank_responder
  import hci_package::*;
#(
  parameter int unsigned AW         = 32,
  parameter int unsigned DW         = 32,
  parameter int unsigned BW         = 8,
  parameter int unsigned IW         = 20,
  parameter int unsigned N_WORDS    = 1024,
  parameter int unsigned LATENCY    = 1,
  parameter int unsigned STALL_RATE = 0,
  parameter logic [HCI_STALL_LFSR_W-1:0] LFSR_SEED = HCI_STALL_LFSR_SEED
`ifdef HCI_MEM_BANK_RESPONDER_TS_EN
  ,
  parameter int unsigned TS_BIT     = 21
`endif
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clear_i,
  input  logic             req_i,
  output logic             gnt_o,
  input  logic [AW-1:0]    add_i,
  input  logic             wen_i,
  input  logic [DW-1:0]    data_i,
  input  logic [DW/BW-1:0] be_i,
  input  logic [IW-1:0]    id_i,
  output logic [DW-1:0]    r_data_o,
  output logic [IW-1:0]    r_id_o,
  output logic             r_valid_o
);

  localparam int unsigned NBE  = DW / BW;
  localparam int unsigned OFFW = $clog2(DW / 8);
  localparam int unsigned IDXW = $clog2(N_WORDS);

  logic [DW-1:0]               r_mem [N_WORDS];
  logic [LATENCY-1:0]          r_pv;
  logic [LATENCY-1:0][IW-1:0]  r_pid;
  logic [LATENCY-1:0][DW-1:0]  r_pdata;

  logic [HCI_STALL_LFSR_W-1:0] w_lfsr;
  logic [AW-1:0]               w_add;
  logic [IDXW-1:0]             w_idx;
  logic                        w_accept;
  logic                        w_read;
  logic                        w_write;
  logic                        w_unused;

  hci_mem_bank_responder_lfsr #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .i_clk   (clk_i),
    .i_rst_n (rst_ni),
    .i_en    (1'b1),
    .i_clear (clear_i),
    .o_state (w_lfsr)
  );

  // Grant comes purely from registered LFSR state; 5-bit compare lets 16 mean never.
  assign gnt_o = !({1'b0, w_lfsr[3:0]} < 5'(STALL_RATE));

  assign w_accept = req_i & gnt_o;
  assign w_read   = w_accept & (wen_i == HCI_OP_READ);
  assign w_write  = w_accept & (wen_i == HCI_OP_WRITE);

`ifdef HCI_MEM_BANK_RESPONDER_TS_EN
  logic w_ts;
  assign w_ts = add_i[TS_BIT];
  // Index address with the test-and-set flag bit forced out.
  always_comb begin
    w_add         = add_i;
    w_add[TS_BIT] = 1'b0;
  end
`else
  assign w_add = add_i;
`endif

  // Byte offset and high bits drop out, so addresses alias modulo the array.
  assign w_idx    = w_add[OFFW +: IDXW];
  assign w_unused = ^{w_add, w_lfsr};

  // Array write port: byte-enabled writes and the test-and-set all-ones store.
  always_ff @(posedge clk_i) begin
    if (w_write) begin
      for (int unsigned k = 0; k < NBE; k++) begin
        if (be_i[k]) r_mem[w_idx][k*BW +: BW] <= data_i[k*BW +: BW];
      end
    end
`ifdef HCI_MEM_BANK_RESPONDER_TS_EN
    else if (w_read && w_ts) begin
      r_mem[w_idx] <= '1;
    end
`endif
  end

  // Response pipeline: capture old word at accept, shift LATENCY stages; clear drops valids.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_pv    <= '0;
      r_pid   <= '0;
      r_pdata <= '0;
    end else begin
      r_pv[0] <= w_read & ~clear_i;
      if (w_read) begin
        r_pid[0]   <= id_i;
        r_pdata[0] <= r_mem[w_idx];
      end
      for (int unsigned i = 1; i < LATENCY; i++) begin
        r_pv[i]    <= r_pv[i-1] & ~clear_i;
        r_pid[i]   <= r_pid[i-1];
        r_pdata[i] <= r_pdata[i-1];
      end
    end
  end

  assign r_valid_o = r_pv[LATENCY-1];
  assign r_id_o    = r_pid[LATENCY-1];
  assign r_data_o  = r_pdata[LATENCY-1];

endmodule

// File: tb/tb_hci_mem_bank_responder.sv
// Bench for hci_mem_bank_responder: LATENCY=2 and LATENCY=3 instances share
// stimulus; a LATENCY=4, STALL_RATE=8 instance covers stalling and clear.
module tb_hci_mem_bank_responder;

`ifdef HCI_MEM_BANK_RESPONDER_TS_EN
  localparam logic [31:0] TS_AFTER = 32'hFFFF_FFFF;
`else
  localparam logic [31:0] TS_AFTER = 32'h0000_0000;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        req_a = 1'b0, req_s = 1'b0, clear_s = 1'b0;
  logic        wen = 1'b1;
  logic [31:0] add = '0, data = '0;
  logic [3:0]  be = '0;
  logic [19:0] id = '0;

  logic gnt_2, rv_2, gnt_3, rv_3, gnt_s, rv_s;
  logic [31:0] rd_2, rd_3, rd_s;
  logic [19:0] rid_2, rid_3, rid_s;

  hci_mem_bank_responder #(.LATENCY(2)) u_l2 (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(1'b0), .req_i(req_a), .gnt_o(gnt_2),
    .add_i(add), .wen_i(wen), .data_i(data), .be_i(be), .id_i(id),
    .r_data_o(rd_2), .r_id_o(rid_2), .r_valid_o(rv_2));

  hci_mem_bank_responder #(.LATENCY(3)) u_l3 (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(1'b0), .req_i(req_a), .gnt_o(gnt_3),
    .add_i(add), .wen_i(wen), .data_i(data), .be_i(be), .id_i(id),
    .r_data_o(rd_3), .r_id_o(rid_3), .r_valid_o(rv_3));

  hci_mem_bank_responder #(.LATENCY(4), .STALL_RATE(8)) u_st (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(clear_s), .req_i(req_s), .gnt_o(gnt_s),
    .add_i(add), .wen_i(wen), .data_i(data), .be_i(be), .id_i(id),
    .r_data_o(rd_s), .r_id_o(rid_s), .r_valid_o(rv_s));

  int unsigned n_chk = 0, n_pass = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  typedef struct {
    logic        wen;
    logic [31:0] add;
    logic [31:0] data;
    logic [3:0]  be;
    logic [19:0] id;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[16];

  // One op on the shared port, then watch both latency instances for 4 cycles.
  task automatic apply_vec(input vec_t v);
    @(negedge clk);
    check("gnt_l2", gnt_2, 1'b1);
    req_a = 1'b1; wen = v.wen; add = v.add; data = v.data; be = v.be; id = v.id;
    @(negedge clk);
    req_a = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) @(negedge clk);
      check("rvalid_l2", rv_2, (v.wen && k == 1));
      check("rvalid_l3", rv_3, (v.wen && k == 2));
      if (v.wen && k == 1) begin
        check("rdata_l2", rd_2, v.exp);
        check("rid_l2", rid_2, v.id);
      end
      if (v.wen && k == 2) begin
        check("rdata_l3", rd_3, v.exp);
        check("rid_l3", rid_3, v.id);
      end
    end
  endtask

  typedef struct {
    logic [19:0] id;
    logic [31:0] d;
    int unsigned t;
  } exp_t;

  exp_t        q[$];
  logic [31:0] model[16];
  int unsigned nreads = 0, nresp = 0, gcnt = 0, ncyc = 0;

  task automatic mon_st();
    exp_t e;
    if (rv_s) begin
      nresp++;
      if (q.size() == 0) check("st_unexpected_resp", 1'b1, 1'b0);
      else begin
        e = q.pop_front();
        check("st_resp", {rid_s, rd_s, 32'(cyc)}, {e.id, e.d, 32'(e.t)});
      end
    end
  endtask

  // Hold a request on the stall instance until granted (bounded).
  task automatic st_issue(input logic w, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] b, input logic [19:0] i, output int unsigned t_acc);
    @(negedge clk);
    req_s = 1'b1; wen = w; add = a; data = d; be = b; id = i;
    for (int n = 0; n < 64 && !gnt_s; n++) @(negedge clk);
    if (!gnt_s) check("st_grant_timeout", 1'b0, 1'b1);
    t_acc = cyc;
  endtask

  logic        need_new;
  int unsigned op, t_acc;
  logic [3:0]  wsel;
  logic        got;
  logic [31:0] exp_b2b[3];

  initial begin
    vecs[0]  = '{1'b0, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 20'h0,     32'h0};
    vecs[1]  = '{1'b1, 32'h0000_0010, 32'h0,         4'h0, 20'h5,     32'hDEAD_BEEF};
    vecs[2]  = '{1'b0, 32'h0000_0020, 32'hFFFF_FFFF, 4'hF, 20'h0,     32'h0};
    vecs[3]  = '{1'b0, 32'h0000_0020, 32'h1122_3344, 4'h5, 20'h0,     32'h0};
    vecs[4]  = '{1'b1, 32'h0000_0020, 32'h0,         4'h0, 20'h7,     32'hFF22_FF44};
    vecs[5]  = '{1'b0, 32'h0000_0000, 32'hA0A0_A0A0, 4'hF, 20'h0,     32'h0};
    vecs[6]  = '{1'b0, 32'h0000_0004, 32'hB1B1_B1B1, 4'hF, 20'h0,     32'h0};
    vecs[7]  = '{1'b0, 32'h0000_0008, 32'hC2C2_C2C2, 4'hF, 20'h0,     32'h0};
    vecs[8]  = '{1'b0, 32'h0000_0010, 32'h0,         4'h0, 20'h0,     32'h0};
    vecs[9]  = '{1'b1, 32'h0000_0013, 32'h0,         4'h0, 20'h9,     32'hDEAD_BEEF};
    vecs[10] = '{1'b1, 32'h0000_1010, 32'h0,         4'h0, 20'h3,     32'hDEAD_BEEF};
    vecs[11] = '{1'b0, 32'h0000_200F, 32'h1234_5678, 4'hF, 20'h0,     32'h0};
    vecs[12] = '{1'b1, 32'h0000_000C, 32'h0,         4'h0, 20'hFFFFF, 32'h1234_5678};
    vecs[13] = '{1'b0, 32'h0000_0040, 32'h0,         4'hF, 20'h0,     32'h0};
    vecs[14] = '{1'b1, 32'h0020_0040, 32'h0,         4'h0, 20'hA,     32'h0};
    vecs[15] = '{1'b1, 32'h0000_0040, 32'h0,         4'h0, 20'hB,     TS_AFTER};
    exp_b2b[0] = 32'hA0A0_A0A0; exp_b2b[1] = 32'hB1B1_B1B1; exp_b2b[2] = 32'hC2C2_C2C2;

    // Reset state
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_rvalid", {rv_2, rv_3, rv_s}, 3'b000);
    check("rst_rdata", {rd_2, rd_3, rd_s}, 96'h0);
    check("rst_rid", {rid_2, rid_3, rid_s}, 60'h0);
    check("rst_gnt_nostall", {gnt_2, gnt_3}, 2'b11);
    check("rst_gnt_stall_seed", gnt_s, 1'b0);
    rst_n = 1'b1;

    // Table-driven ops
    for (int v = 0; v < 16; v++) apply_vec(vecs[v]);

    // Back-to-back reads of words 0,1,2
    @(negedge clk);
    req_a = 1'b1; wen = 1'b1; add = 32'h0; id = 20'h1;
    for (int n = 1; n <= 6; n++) begin
      @(negedge clk);
      if (n == 1) begin add = 32'h4; id = 20'h2; end
      else if (n == 2) begin add = 32'h8; id = 20'h3; end
      else if (n == 3) req_a = 1'b0;
      check("b2b_rvalid_l2", rv_2, (n >= 2 && n <= 4));
      check("b2b_rvalid_l3", rv_3, (n >= 3 && n <= 5));
      if (n >= 2 && n <= 4) check("b2b_l2", {rid_2, rd_2}, {20'(n - 1), exp_b2b[n-2]});
      if (n >= 3 && n <= 5) check("b2b_l3", {rid_3, rd_3}, {20'(n - 2), exp_b2b[n-3]});
    end

    // Read-after-write on consecutive accepts
    @(negedge clk);
    req_a = 1'b1; wen = 1'b0; add = 32'h50; data = 32'h5A5A_5A5A; be = 4'hF;
    @(negedge clk);
    wen = 1'b1; id = 20'h77;
    @(negedge clk);
    req_a = 1'b0;
    @(negedge clk);
    check("raw_rvalid_l2", rv_2, 1'b1);
    check("raw_l2", {rid_2, rd_2}, {20'h77, 32'h5A5A_5A5A});

    // Stall instance: 1000 held-until-granted requests against a scoreboard
    need_new = 1'b1; op = 0;
    for (int c = 0; c < 20000 && op < 1000; c++) begin
      @(negedge clk);
      mon_st();
      ncyc++;
      if (gnt_s) gcnt++;
      if (need_new) begin
        req_s = 1'b1;
        data = $urandom;
        id = 20'($urandom);
        if (op < 16) begin
          wen = 1'b0; be = 4'hF; add = 32'(op) << 2;
        end else begin
          wen = 1'($urandom_range(0, 1));
          be = 4'($urandom_range(0, 15));
          add = ($urandom & 32'hFFDF_F000) | 32'($urandom_range(0, 63));
        end
      end
      if (req_s && gnt_s) begin
        wsel = add[5:2];
        if (!wen) begin
          for (int k = 0; k < 4; k++)
            if (be[k]) model[wsel][k*8 +: 8] = data[k*8 +: 8];
        end else begin
          q.push_back('{id, model[wsel], cyc + 4});
          nreads++;
        end
        op++;
        need_new = 1'b1;
      end else begin
        need_new = 1'b0;
      end
    end
    check("st_ops_done", op, 1000);
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      req_s = 1'b0;
      mon_st();
    end
    check("st_queue_drained", q.size(), 0);
    check("st_resp_count", nresp, nreads);
    check("st_duty_in_range", (gcnt * 100 >= ncyc * 35) && (gcnt * 100 <= ncyc * 65), 1'b1);

    // clear_i one cycle after a read accept flushes it and reloads the seed
    st_issue(1'b1, 32'h8, 32'h0, 4'h0, 20'h123, t_acc);
    @(negedge clk);
    req_s = 1'b0; clear_s = 1'b1;
    check("clr_rvalid", rv_s, 1'b0);
    @(negedge clk);
    clear_s = 1'b0;
    check("clr_gnt_seed", gnt_s, 1'b0);
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      check("clr_rvalid_flushed", rv_s, 1'b0);
    end
    st_issue(1'b1, 32'h14, 32'h0, 4'h0, 20'h321, t_acc);
    got = 1'b0;
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      req_s = 1'b0;
      if (rv_s && !got) begin
        got = 1'b1;
        check("post_clr_read", {rid_s, rd_s, 32'(cyc)}, {20'h321, model[5], 32'(t_acc + 4)});
      end
    end
    check("post_clr_resp_seen", got, 1'b1);

    // Asynchronous reset while a response is on the output
    @(negedge clk);
    req_a = 1'b1; wen = 1'b1; add = 32'h10; id = 20'h5;
    @(negedge clk);
    req_a = 1'b0;
    @(negedge clk);
    check("pre_rst_rvalid_l2", rv_2, 1'b1);
    #1 rst_n = 1'b0;
    #1 check("async_rst_rvalid_l2", rv_2, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
